// File: rtl/master_port_pkg.sv
// ---------------------------------------------------------------------------
// master_port_pkg
// Shared types and helpers for the serial-bus master port:
//   - state_t     : transaction FSM states
//   - MODE_READ / MODE_WRITE : command mode encodings
//   - calc_mem_w / calc_hdr_len : memory-address and header field sizes
//   - calc_cnt_w  : counter width for a count range of n values (min 1 bit)
// ---------------------------------------------------------------------------
package master_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_HDR   = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Memory address bits carried in the header (slave bits are sent out-of-band on mslave).
    function automatic int calc_mem_w(input int addr_width, input int slave_addr_width);
        return addr_width - slave_addr_width;
    endfunction

    // Header = memory address followed by the burst length field.
    function automatic int calc_hdr_len(input int addr_width, input int slave_addr_width,
                                        input int burst_width);
        return calc_mem_w(addr_width, slave_addr_width) + burst_width;
    endfunction

    // Index width for a counter spanning n positions; never narrower than one bit.
    function automatic int calc_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/master_port_v2_if.sv
// ---------------------------------------------------------------------------
// master_port_v2_if
// Groups the device-side command/data handshake and the serial bus signals.
//   modport master : view of the master port itself (drives dready, status,
//                    read data and all bus outputs)
//   modport slave  : view of the surrounding device / bus / arbiter
// Device side : dvalid, dready, dmode, daddr, dlen, dwdata, dwack,
//               drdata, drvalid, ddone, derr
// Bus side    : mwdata, mvalid, mmode, mslave, mrdata, svalid, mbreq, mbgrant
// ---------------------------------------------------------------------------
interface master_port_v2_if #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int SLAVE_ADDR_WIDTH = 4,
    parameter int BURST_WIDTH      = 2
);
    logic                        dvalid;
    logic                        dready;
    logic                        dmode;
    logic [ADDR_WIDTH-1:0]       daddr;
    logic [BURST_WIDTH-1:0]      dlen;
    logic [DATA_WIDTH-1:0]       dwdata;
    logic                        dwack;
    logic [DATA_WIDTH-1:0]       drdata;
    logic                        drvalid;
    logic                        ddone;
    logic                        derr;
    logic                        mwdata;
    logic                        mvalid;
    logic                        mmode;
    logic [SLAVE_ADDR_WIDTH-1:0] mslave;
    logic                        mrdata;
    logic                        svalid;
    logic                        mbreq;
    logic                        mbgrant;

    modport master (
        input  dvalid, dmode, daddr, dlen, dwdata, mrdata, svalid, mbgrant,
        output dready, dwack, drdata, drvalid, ddone, derr,
               mwdata, mvalid, mmode, mslave, mbreq
    );

    modport slave (
        output dvalid, dmode, daddr, dlen, dwdata, mrdata, svalid, mbgrant,
        input  dready, dwack, drdata, drvalid, ddone, derr,
               mwdata, mvalid, mmode, mslave, mbreq
    );
endinterface

// File: rtl/master_port_shifter.sv
// ---------------------------------------------------------------------------
// master_port_shifter
// DATA_WIDTH beat register with a bit index, used as PISO for write beats and
// SIPO for read beats. Bits are addressed by bitcnt (LSB first).
// Ports:
//   clk, rstn   : clock, async active-low reset
//   clr         : zero the register and the bit index
//   load        : parallel-load load_data, bit index to 0
//   step        : advance the bit index (wraps after the last bit)
//   capture     : with step, write in_bit at the current bit index
//   bit_out     : bit at the current index
//   next_bit    : bit at the following index (for a registered serial output)
//   last_bit    : current index is the last bit of the beat
//   cap_data    : register contents with in_bit merged at the current index
// ---------------------------------------------------------------------------
module master_port_shifter
    import master_port_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  step,
    input  logic                  capture,
    input  logic                  in_bit,
    output logic                  bit_out,
    output logic                  next_bit,
    output logic                  last_bit,
    output logic [DATA_WIDTH-1:0] cap_data
);
    localparam int CNT_W = calc_cnt_w(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] data_r;
    logic [CNT_W-1:0]      bitcnt_r;
    logic [CNT_W-1:0]      bitcnt_nxt_s;

    assign last_bit     = (bitcnt_r == CNT_W'(DATA_WIDTH - 1));
    assign bitcnt_nxt_s = last_bit ? {CNT_W{1'b0}} : (bitcnt_r + CNT_W'(1));
    assign bit_out      = data_r[bitcnt_r];
    assign next_bit     = data_r[bitcnt_nxt_s];

    // Read beat as it will look once the bit arriving this cycle is stored.
    always_comb begin
        cap_data           = data_r;
        cap_data[bitcnt_r] = in_bit;
    end

    // Beat register and bit index; clear wins over load, load over step.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_r   <= {DATA_WIDTH{1'b0}};
            bitcnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            data_r   <= {DATA_WIDTH{1'b0}};
            bitcnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            data_r   <= load_data;
            bitcnt_r <= {CNT_W{1'b0}};
        end else if (step) begin
            if (capture) begin
                data_r[bitcnt_r] <= in_bit;
            end
            bitcnt_r <= bitcnt_nxt_s;
        end
    end

endmodule

// File: rtl/master_port_v2.sv
// ---------------------------------------------------------------------------
// master_port_v2
// Serial-bus master port. Accepts a single/multi-beat command, requests the
// bus, sends header (memory address then length, LSB first) and write beats
// on mwdata, or collects read beats from mrdata on svalid.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : master_port_v2_if.master (device handshake + serial bus)
// Optional build macro: MASTER_PORT_TIMEOUT_EN -- aborts a read with derr=1
// after TIMEOUT_CYCLES consecutive cycles without svalid.
// ---------------------------------------------------------------------------
module master_port_v2
    import master_port_pkg::*;
#(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int SLAVE_ADDR_WIDTH = 4,
    parameter int BURST_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input logic              clk,
    input logic              rstn,
    master_port_v2_if.master bus
);
    localparam int MEM_W     = calc_mem_w(ADDR_WIDTH, SLAVE_ADDR_WIDTH);
    localparam int HDR_LEN   = calc_hdr_len(ADDR_WIDTH, SLAVE_ADDR_WIDTH, BURST_WIDTH);
    localparam int HDR_CNT_W = calc_cnt_w(HDR_LEN);

    state_t                      state_r;
    logic                        dready_r;
    logic                        dwack_r;
    logic [DATA_WIDTH-1:0]       drdata_r;
    logic                        drvalid_r;
    logic                        ddone_r;
    logic                        mwdata_r;
    logic                        mvalid_r;
    logic                        mmode_r;
    logic [SLAVE_ADDR_WIDTH-1:0] mslave_r;
    logic                        mbreq_r;
    logic [BURST_WIDTH-1:0]      len_r;
    logic [HDR_LEN-1:0]          hdr_r;
    logic [HDR_CNT_W-1:0]        hdr_cnt_r;
    logic [BURST_WIDTH-1:0]      beatcnt_r;
    logic                        rd_fin_r;

    logic                        hdr_last_s;
    logic                        beat_final_s;
    logic                        sh_clr_s;
    logic                        sh_load_s;
    logic                        sh_step_s;
    logic                        sh_capture_s;
    logic                        sh_bit_out_s;
    logic                        sh_next_bit_s;
    logic                        sh_last_bit_s;
    logic [DATA_WIDTH-1:0]       sh_cap_data_s;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TO_W = calc_cnt_w(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt_r;
    logic            derr_r;
    assign bus.derr = derr_r;
`else
    assign bus.derr = 1'b0;
`endif

    assign bus.dready  = dready_r;
    assign bus.dwack   = dwack_r;
    assign bus.drdata  = drdata_r;
    assign bus.drvalid = drvalid_r;
    assign bus.ddone   = ddone_r;
    assign bus.mwdata  = mwdata_r;
    assign bus.mvalid  = mvalid_r;
    assign bus.mmode   = mmode_r;
    assign bus.mslave  = mslave_r;
    assign bus.mbreq   = mbreq_r;

    assign hdr_last_s   = (hdr_cnt_r == HDR_CNT_W'(HDR_LEN - 1));
    assign beat_final_s = (beatcnt_r == len_r);

    master_port_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (sh_clr_s),
        .load      (sh_load_s),
        .load_data (bus.dwdata),
        .step      (sh_step_s),
        .capture   (sh_capture_s),
        .in_bit    (bus.mrdata),
        .bit_out   (sh_bit_out_s),
        .next_bit  (sh_next_bit_s),
        .last_bit  (sh_last_bit_s),
        .cap_data  (sh_cap_data_s)
    );

    // Shifter control: load beats on accept and between write beats, step on every data bit.
    always_comb begin
        sh_clr_s     = 1'b0;
        sh_load_s    = 1'b0;
        sh_step_s    = 1'b0;
        sh_capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.dvalid) begin
                    sh_load_s = 1'b1;
                end else begin
                    sh_load_s = 1'b0;
                end
            end
            ST_HDR: begin
                if (hdr_last_s && (mmode_r == MODE_READ)) begin
                    sh_clr_s = 1'b1;
                end else begin
                    sh_clr_s = 1'b0;
                end
            end
            ST_WDATA: begin
                if (sh_last_bit_s) begin
                    sh_load_s = !beat_final_s;
                end else begin
                    sh_step_s = 1'b1;
                end
            end
            ST_RDATA: begin
                if (!rd_fin_r && bus.svalid) begin
                    sh_step_s    = 1'b1;
                    sh_capture_s = 1'b1;
                end else begin
                    sh_step_s    = 1'b0;
                end
            end
            default: begin
                sh_clr_s = 1'b0;
            end
        endcase
    end

    // Transaction FSM with all device and bus outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            dready_r   <= 1'b1;
            dwack_r    <= 1'b0;
            drdata_r   <= {DATA_WIDTH{1'b0}};
            drvalid_r  <= 1'b0;
            ddone_r    <= 1'b0;
            mwdata_r   <= 1'b0;
            mvalid_r   <= 1'b0;
            mmode_r    <= 1'b0;
            mslave_r   <= {SLAVE_ADDR_WIDTH{1'b0}};
            mbreq_r    <= 1'b0;
            len_r      <= {BURST_WIDTH{1'b0}};
            hdr_r      <= {HDR_LEN{1'b0}};
            hdr_cnt_r  <= {HDR_CNT_W{1'b0}};
            beatcnt_r  <= {BURST_WIDTH{1'b0}};
            rd_fin_r   <= 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
            idle_cnt_r <= {TO_W{1'b0}};
            derr_r     <= 1'b0;
`endif
        end else begin
            dwack_r   <= 1'b0;
            drvalid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.dvalid) begin
                        dready_r  <= 1'b0;
                        dwack_r   <= 1'b1;
                        mmode_r   <= bus.dmode;
                        mslave_r  <= bus.daddr[ADDR_WIDTH-1 -: SLAVE_ADDR_WIDTH];
                        len_r     <= bus.dlen;
                        hdr_r     <= {bus.dlen, bus.daddr[MEM_W-1:0]};
                        mbreq_r   <= 1'b1;
                        state_r   <= ST_REQ;
                    end else begin
                        dready_r  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // First header bit goes out with the same edge that leaves REQ.
                    if (bus.mbgrant) begin
                        mvalid_r  <= 1'b1;
                        mwdata_r  <= hdr_r[0];
                        hdr_r     <= {1'b0, hdr_r[HDR_LEN-1:1]};
                        hdr_cnt_r <= {HDR_CNT_W{1'b0}};
                        state_r   <= ST_HDR;
                    end else begin
                        state_r   <= ST_REQ;
                    end
                end
                ST_HDR: begin
                    if (hdr_last_s) begin
                        hdr_cnt_r <= {HDR_CNT_W{1'b0}};
                        beatcnt_r <= {BURST_WIDTH{1'b0}};
                        if (mmode_r == MODE_WRITE) begin
                            // Beat 0 bit 0 follows the header with no gap.
                            mwdata_r <= sh_bit_out_s;
                            state_r  <= ST_WDATA;
                        end else begin
                            mvalid_r <= 1'b0;
                            mwdata_r <= 1'b0;
                            rd_fin_r <= 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
                            idle_cnt_r <= {TO_W{1'b0}};
`endif
                            state_r  <= ST_RDATA;
                        end
                    end else begin
                        mwdata_r  <= hdr_r[0];
                        hdr_r     <= {1'b0, hdr_r[HDR_LEN-1:1]};
                        hdr_cnt_r <= hdr_cnt_r + HDR_CNT_W'(1);
                    end
                end
                ST_WDATA: begin
                    if (sh_last_bit_s) begin
                        if (beat_final_s) begin
                            mvalid_r  <= 1'b0;
                            mwdata_r  <= 1'b0;
                            mbreq_r   <= 1'b0;
                            ddone_r   <= 1'b1;
                            beatcnt_r <= {BURST_WIDTH{1'b0}};
                            state_r   <= ST_DONE;
                        end else begin
                            // Next beat is latched by the shifter this same edge.
                            mwdata_r  <= bus.dwdata[0];
                            dwack_r   <= 1'b1;
                            beatcnt_r <= beatcnt_r + BURST_WIDTH'(1);
                        end
                    end else begin
                        mwdata_r <= sh_next_bit_s;
                    end
                end
                ST_RDATA: begin
                    if (rd_fin_r) begin
                        // One spare cycle so ddone trails the final drvalid.
                        rd_fin_r <= 1'b0;
                        mbreq_r  <= 1'b0;
                        ddone_r  <= 1'b1;
                        state_r  <= ST_DONE;
                    end else if (bus.svalid) begin
`ifdef MASTER_PORT_TIMEOUT_EN
                        idle_cnt_r <= {TO_W{1'b0}};
`endif
                        if (sh_last_bit_s) begin
                            drdata_r  <= sh_cap_data_s;
                            drvalid_r <= 1'b1;
                            if (beat_final_s) begin
                                rd_fin_r  <= 1'b1;
                                beatcnt_r <= {BURST_WIDTH{1'b0}};
                            end else begin
                                beatcnt_r <= beatcnt_r + BURST_WIDTH'(1);
                            end
                        end else begin
                            drvalid_r <= 1'b0;
                        end
                    end else begin
`ifdef MASTER_PORT_TIMEOUT_EN
                        if (idle_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            idle_cnt_r <= {TO_W{1'b0}};
                            beatcnt_r  <= {BURST_WIDTH{1'b0}};
                            mbreq_r    <= 1'b0;
                            ddone_r    <= 1'b1;
                            derr_r     <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + TO_W'(1);
                        end
`else
                        state_r <= ST_RDATA;
`endif
                    end
                end
                ST_DONE: begin
                    ddone_r  <= 1'b0;
                    dready_r <= 1'b1;
                    mmode_r  <= 1'b0;
                    mslave_r <= {SLAVE_ADDR_WIDTH{1'b0}};
`ifdef MASTER_PORT_TIMEOUT_EN
                    derr_r   <= 1'b0;
`endif
                    state_r  <= ST_IDLE;
                end
                default: begin
                    dready_r <= 1'b1;
                    mvalid_r <= 1'b0;
                    mbreq_r  <= 1'b0;
                    ddone_r  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_master_port_v2.sv
// ---------------------------------------------------------------------------
// tb_master_port_v2
// Directed bench for master_port_v2: reset mid-write, single write, write
// burst, read with svalid gaps, delayed grant, and (with
// MASTER_PORT_TIMEOUT_EN) a read timeout with TIMEOUT_CYCLES=16.
// ---------------------------------------------------------------------------
module tb_master_port_v2;

    logic clk;
    logic rstn;

    int tests;
    int fails;

    // Per-transaction observations.
    logic [63:0] r_stream;
    int          r_nbits;
    int          r_nrise;
    int          r_nack;
    int          r_nrv;
    logic [7:0]  r_rd [4];
    logic        r_done;
    logic        r_done_after;
    logic        r_derr;
    logic        r_mbreq_at_done;
    int          r_first_mv;
    int          r_bad_req;
    int          r_slave_bad;
    int          r_mode_bad;
    int          r_last_sv;
    int          r_done_cyc;

    master_port_v2_if #(
        .ADDR_WIDTH       (16),
        .DATA_WIDTH       (8),
        .SLAVE_ADDR_WIDTH (4),
        .BURST_WIDTH      (2)
    ) bus_if ();

    master_port_v2 #(
        .ADDR_WIDTH       (16),
        .DATA_WIDTH       (8),
        .SLAVE_ADDR_WIDTH (4),
        .BURST_WIDTH      (2),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command at the current negedge and play device/arbiter/slave
    // until ddone (bounded). Read data bits come from the beat list.
    task automatic run_txn(input logic mode, input logic [15:0] addr, input logic [1:0] len,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [3:0] exp_slave, input int grant_delay,
                           input int rd_bits);
        logic [7:0] beats [4];
        int  ack_idx;
        int  sent;
        int  gap;
        bit  prev_mv;
        bit  prev_rv;
        bit  sending;
        beats = '{b0, b1, b2, b3};
        r_stream = 64'd0; r_nbits = 0; r_nrise = 0; r_nack = 0; r_nrv = 0;
        r_done = 1'b0; r_done_after = 1'b0; r_derr = 1'b0; r_mbreq_at_done = 1'b1;
        r_first_mv = 0; r_bad_req = 0; r_slave_bad = 0; r_mode_bad = 0;
        r_last_sv = 0; r_done_cyc = 0;
        for (int i = 0; i < 4; i++) r_rd[i] = 8'h00;
        ack_idx = 0; sent = 0; gap = 0; prev_mv = 1'b0; prev_rv = 1'b0; sending = 1'b0;

        bus_if.dmode   = mode;
        bus_if.daddr   = addr;
        bus_if.dlen    = len;
        bus_if.dwdata  = b0;
        bus_if.mbgrant = (grant_delay == 0);
        bus_if.dvalid  = 1'b1;
        for (int cyc = 1; cyc <= 800 && !r_done; cyc++) begin
            @(negedge clk);
            bus_if.dvalid = 1'b0;
            if (bus_if.mslave !== exp_slave) r_slave_bad++;
            if (bus_if.mmode !== mode) r_mode_bad++;
            if (!bus_if.ddone && bus_if.mbreq !== 1'b1) r_bad_req++;
            if (!bus_if.ddone && cyc < r_first_mv && bus_if.mvalid) r_bad_req++;
            if (bus_if.dwack) begin
                r_nack++;
                ack_idx++;
                if (ack_idx < 4) bus_if.dwdata = beats[ack_idx];
            end
            if (bus_if.mvalid) begin
                if (r_nbits < 64) r_stream[r_nbits] = bus_if.mwdata;
                r_nbits++;
                if (!prev_mv) r_nrise++;
                if (r_first_mv == 0) r_first_mv = cyc;
            end
            if (bus_if.drvalid) begin
                if (r_nrv < 4) r_rd[r_nrv] = bus_if.drdata;
                r_nrv++;
            end
            if (bus_if.ddone) begin
                r_done          = 1'b1;
                r_done_after    = mode ? prev_mv : prev_rv;
                r_derr          = bus_if.derr;
                r_mbreq_at_done = bus_if.mbreq;
                r_done_cyc      = cyc;
            end
            if (cyc == grant_delay) bus_if.mbgrant = 1'b1;
            if (!mode && prev_mv && !bus_if.mvalid) sending = 1'b1;
            if (sending && sent < rd_bits && !r_done) begin
                if (gap > 0) begin
                    bus_if.svalid = 1'b0;
                    gap--;
                end else begin
                    bus_if.svalid = 1'b1;
                    bus_if.mrdata = beats[sent / 8][sent % 8];
                    gap = sent % 4;
                    sent++;
                    r_last_sv = cyc;
                end
            end else begin
                bus_if.svalid = 1'b0;
            end
            prev_mv = bus_if.mvalid;
            prev_rv = bus_if.drvalid;
        end
        bus_if.svalid = 1'b0;
        chk("done_seen", {63'd0, r_done}, 64'd1);
    endtask

    task automatic chk_idle_after(input string tag);
        @(negedge clk);
        chk({tag, "_dready"}, {63'd0, bus_if.dready}, 64'd1);
        chk({tag, "_ddone_low"}, {63'd0, bus_if.ddone}, 64'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn = 1'b0;
        bus_if.dvalid = 1'b0; bus_if.dmode = 1'b0; bus_if.daddr = 16'h0000;
        bus_if.dlen = 2'd0; bus_if.dwdata = 8'h00; bus_if.mrdata = 1'b0;
        bus_if.svalid = 1'b0; bus_if.mbgrant = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_dready", {63'd0, bus_if.dready}, 64'd1);
        chk("rst_mvalid", {63'd0, bus_if.mvalid}, 64'd0);
        chk("rst_mbreq",  {63'd0, bus_if.mbreq},  64'd0);
        chk("rst_ddone",  {63'd0, bus_if.ddone},  64'd0);
        chk("rst_dwack",  {63'd0, bus_if.dwack},  64'd0);
        chk("rst_mslave", {60'd0, bus_if.mslave}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Async reset in the middle of the write data phase
        bus_if.mbgrant = 1'b1; bus_if.dmode = 1'b1; bus_if.daddr = 16'h3A5C;
        bus_if.dlen = 2'd0; bus_if.dwdata = 8'hC3; bus_if.dvalid = 1'b1;
        @(negedge clk);
        bus_if.dvalid = 1'b0;
        repeat (17) @(negedge clk);
        chk("midrst_pre_mvalid", {63'd0, bus_if.mvalid}, 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_mvalid", {63'd0, bus_if.mvalid}, 64'd0);
        chk("midrst_mbreq",  {63'd0, bus_if.mbreq},  64'd0);
        chk("midrst_ddone",  {63'd0, bus_if.ddone},  64'd0);
        chk("midrst_dready", {63'd0, bus_if.dready}, 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Single write 3A5C / C3: stream A5C, 00, C3 (LSB first)
        run_txn(1'b1, 16'h3A5C, 2'd0, 8'hC3, 8'h00, 8'h00, 8'h00, 4'h3, 0, 0);
        chk("wr1_nbits",   r_nbits, 64'd22);
        chk("wr1_stream",  r_stream & 64'h3F_FFFF, 64'h30_CA5C);
        chk("wr1_rises",   r_nrise, 64'd1);
        chk("wr1_first_mv", r_first_mv, 64'd2);
        chk("wr1_slave",   r_slave_bad, 64'd0);
        chk("wr1_mode",    r_mode_bad, 64'd0);
        chk("wr1_req",     r_bad_req, 64'd0);
        chk("wr1_nack",    r_nack, 64'd1);
        chk("wr1_done_after_last", {63'd0, r_done_after}, 64'd1);
        chk("wr1_derr",    {63'd0, r_derr}, 64'd0);
        chk("wr1_mbreq_done", {63'd0, r_mbreq_at_done}, 64'd0);
        chk_idle_after("wr1");

        // Write burst of four beats
        run_txn(1'b1, 16'h1234, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44, 4'h1, 0, 0);
        chk("wrb_nbits",  r_nbits, 64'd46);
        chk("wrb_stream", r_stream & 64'h3FFF_FFFF_FFFF,
            {18'd0, 8'h44, 8'h33, 8'h22, 8'h11, 2'b11, 12'h234});
        chk("wrb_rises",  r_nrise, 64'd1);
        chk("wrb_nack",   r_nack, 64'd4);
        chk("wrb_slave",  r_slave_bad, 64'd0);
        chk("wrb_req",    r_bad_req, 64'd0);
        chk("wrb_done_after_last", {63'd0, r_done_after}, 64'd1);
        chk_idle_after("wrb");

        // Read of two beats with svalid gaps 0..3
        run_txn(1'b0, 16'h7010, 2'd1, 8'h5A, 8'hF0, 8'h00, 8'h00, 4'h7, 0, 16);
        chk("rd_hdr_nbits", r_nbits, 64'd14);
        chk("rd_hdr_stream", r_stream & 64'h3FFF, {50'd0, 2'b01, 12'h010});
        chk("rd_nrv",    r_nrv, 64'd2);
        chk("rd_beat0",  r_rd[0], 64'h5A);
        chk("rd_beat1",  r_rd[1], 64'hF0);
        chk("rd_done_after_rv", {63'd0, r_done_after}, 64'd1);
        chk("rd_derr",   {63'd0, r_derr}, 64'd0);
        chk("rd_slave",  r_slave_bad, 64'd0);
        chk("rd_mode",   r_mode_bad, 64'd0);
        chk("rd_req",    r_bad_req, 64'd0);
        chk_idle_after("rd");

        // Grant held off for 10 cycles
        run_txn(1'b1, 16'hB001, 2'd0, 8'h96, 8'h00, 8'h00, 8'h00, 4'hB, 10, 0);
        chk("gd_first_mv", r_first_mv, 64'd11);
        chk("gd_req",      r_bad_req, 64'd0);
        chk("gd_nbits",    r_nbits, 64'd22);
        chk("gd_stream",   r_stream & 64'h3F_FFFF, {42'd0, 8'h96, 2'b00, 12'h001});
        chk_idle_after("gd");

`ifdef MASTER_PORT_TIMEOUT_EN
        // Slave stops after 3 bits: abort after 16 idle cycles
        run_txn(1'b0, 16'h2000, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h2, 0, 3);
        chk("to_derr",  {63'd0, r_derr}, 64'd1);
        chk("to_nrv",   r_nrv, 64'd0);
        chk("to_mbreq_done", {63'd0, r_mbreq_at_done}, 64'd0);
        chk("to_latency", r_done_cyc - r_last_sv, 64'd17);
        chk_idle_after("to");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
